header_route_latch: RTL and testbench

HEADER_ROUTE_LATCH -- requirements
Module: header_route_latch

---
 rtl/header_route_latch.sv | 130 +++++++++++++
 tb/tb_header_route_latch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/header_route_latch.sv
// Per-VC header route latch. When HEADER_ROUTE_LATCH_DFD_EN is defined, it also builds
// the DfD trigger and trace: header and error counters plus the sticky error flags.
module header_route_vc #(
   parameter int EAw   = 3,
   parameter int DSTPw = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             release_vc,
   input  logic             set_err,
   input  logic [EAw-1:0]   addr_in,
   input  logic [DSTPw-1:0] port_in,
   output logic             route_valid,
   output logic [EAw-1:0]   addr,
   output logic [DSTPw-1:0] port,
   output logic             err_sticky
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         route_valid <= 1'b0;
         addr        <= '0;
         port        <= '0;
         err_sticky  <= 1'b0;
      end else begin
         // A load takes priority over a release in the same cycle.
         if (load) begin
            route_valid <= 1'b1;
            addr        <= addr_in;
            port        <= port_in;
         end else if (release_vc) begin
            route_valid <= 1'b0;
         end
         if (set_err) err_sticky <= 1'b1;
      end
   end
endmodule

module header_route_latch #(
   parameter int V     = 4,
   parameter int EAw   = 3,
   parameter int DSTPw = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flit_in_wr,
   input  logic               hdr_flg_in,
   input  logic               tail_flg_in,
   input  logic [V-1:0]       vc_num_in,
   input  logic [EAw-1:0]     dest_e_addr_in,
   input  logic [DSTPw-1:0]   destport_in,
   input  logic [V-1:0]       pkt_done,
   output logic [V-1:0]       route_valid,
   output logic [V*EAw-1:0]   dest_e_addr_all,
   output logic [V*DSTPw-1:0] destport_all,
   output logic [V-1:0]       err_sticky,
   output logic               trigger,
   output logic [31:0]        trace
);
   logic                      legal_vc;
   logic                      hdr_wr;
   logic [V-1:0]              hdr_err;
   logic [V-1:0]              load;
   logic [V-1:0][EAw-1:0]     addr_q;
   logic [V-1:0][DSTPw-1:0]   port_q;
   logic                      unused_tail;

   // Tail flag does not affect route state; single-flit packets release via pkt_done.
   assign unused_tail = tail_flg_in;

   assign legal_vc = $onehot(vc_num_in);
   assign hdr_wr   = flit_in_wr & hdr_flg_in & legal_vc;
   assign hdr_err  = {V{hdr_wr}} & vc_num_in & route_valid & ~pkt_done;
   assign load     = {V{hdr_wr}} & vc_num_in & ~hdr_err;

   for (genvar i = 0; i < V; i++) begin : g_vc
      header_route_vc #(.EAw(EAw), .DSTPw(DSTPw)) u_vc (
         .clk         (clk),
         .reset       (reset),
         .load        (load[i]),
         .release_vc  (pkt_done[i]),
         .set_err     (hdr_err[i]),
         .addr_in     (dest_e_addr_in),
         .port_in     (destport_in),
         .route_valid (route_valid[i]),
         .addr        (addr_q[i]),
         .port        (port_q[i]),
         .err_sticky  (err_sticky[i])
      );
   end

   assign dest_e_addr_all = addr_q;
   assign destport_all    = port_q;

`ifdef HEADER_ROUTE_LATCH_DFD_EN
   logic        err_evt;
   logic        hdr_acc;
   logic [15:0] hdr_cnt;
   logic [7:0]  err_cnt;
   logic        trig_q;
   logic [7:0]  err_ext;

   // An illegal write and a header error cannot coincide, so one cycle adds at most one error.
   assign err_evt = (flit_in_wr & ~legal_vc) | (|hdr_err);
   assign hdr_acc = |load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hdr_cnt <= '0;
         err_cnt <= '0;
         trig_q  <= 1'b0;
      end else begin
         trig_q <= err_evt;
         if (hdr_acc && hdr_cnt != 16'hFFFF) hdr_cnt <= hdr_cnt + 16'd1;
         if (err_evt && err_cnt != 8'hFF)    err_cnt <= err_cnt + 8'd1;
      end
   end

   always_comb begin
      err_ext        = '0;
      err_ext[V-1:0] = err_sticky;
   end

   assign trigger = trig_q;
   assign trace   = {hdr_cnt, err_cnt, err_ext};
`else
   assign trigger = 1'b0;
   assign trace   = '0;
`endif
endmodule

// File: tb/tb_header_route_latch.sv
// Randomised and directed bench for header_route_latch against a transaction-level model.
module tb_header_route_latch;
   localparam int V = 4, EAw = 3, DSTPw = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               flit_in_wr = 0, hdr_flg_in = 0, tail_flg_in = 0;
   logic [V-1:0]       vc_num_in = '0, pkt_done = '0;
   logic [EAw-1:0]     dest_e_addr_in = '0;
   logic [DSTPw-1:0]   destport_in = '0;
   logic [V-1:0]       route_valid, err_sticky;
   logic [V*EAw-1:0]   dest_e_addr_all;
   logic [V*DSTPw-1:0] destport_all;
   logic               trigger;
   logic [31:0]        trace;

   int vecs = 0, errs = 0;

   // Reference model state
   bit [V-1:0]     m_valid, m_err;
   bit [EAw-1:0]   m_addr [V];
   bit [DSTPw-1:0] m_port [V];
   int             m_hc, m_ec;
   bit             m_trig;

   header_route_latch #(.V(V), .EAw(EAw), .DSTPw(DSTPw)) dut (
      .clk(clk), .reset(reset), .flit_in_wr(flit_in_wr), .hdr_flg_in(hdr_flg_in),
      .tail_flg_in(tail_flg_in), .vc_num_in(vc_num_in), .dest_e_addr_in(dest_e_addr_in),
      .destport_in(destport_in), .pkt_done(pkt_done), .route_valid(route_valid),
      .dest_e_addr_all(dest_e_addr_all), .destport_all(destport_all),
      .err_sticky(err_sticky), .trigger(trigger), .trace(trace));

   always #5 clk = ~clk;

   function automatic void model_clear();
      m_valid = '0; m_err = '0; m_hc = 0; m_ec = 0; m_trig = 0;
      for (int i = 0; i < V; i++) begin m_addr[i] = '0; m_port[i] = '0; end
   endfunction

   // One clock of the protocol rules, applied to the inputs currently driven.
   function automatic void model_update();
      bit [V-1:0] old_valid = m_valid;
      bit ev = 0, acc = 0;
      int ones = $countones(vc_num_in);
      if (flit_in_wr && ones != 1) ev = 1;
      m_valid = m_valid & ~pkt_done;
      if (flit_in_wr && hdr_flg_in && ones == 1) begin
         for (int i = 0; i < V; i++) if (vc_num_in[i]) begin
            if (old_valid[i] && !pkt_done[i]) begin
               m_err[i] = 1; ev = 1;
            end else begin
               m_valid[i] = 1; m_addr[i] = dest_e_addr_in; m_port[i] = destport_in; acc = 1;
            end
         end
      end
      m_trig = ev;
      if (acc && m_hc < 65535) m_hc++;
      if (ev && m_ec < 255) m_ec++;
   endfunction

   function automatic logic [V*EAw-1:0] exp_addr_all();
      logic [V*EAw-1:0] r;
      for (int i = 0; i < V; i++) r[i*EAw +: EAw] = m_addr[i];
      return r;
   endfunction

   function automatic logic [V*DSTPw-1:0] exp_port_all();
      logic [V*DSTPw-1:0] r;
      for (int i = 0; i < V; i++) r[i*DSTPw +: DSTPw] = m_port[i];
      return r;
   endfunction

   function automatic logic [31:0] exp_trace();
`ifdef HEADER_ROUTE_LATCH_DFD_EN
      logic [7:0] e = '0;
      e[V-1:0] = m_err;
      return {16'(m_hc), 8'(m_ec), e};
`else
      return 32'd0;
`endif
   endfunction

   function automatic bit exp_trig();
`ifdef HEADER_ROUTE_LATCH_DFD_EN
      return m_trig;
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input bit wr, input bit hdr, input logic [V-1:0] vc,
                        input logic [EAw-1:0] a, input logic [DSTPw-1:0] p,
                        input logic [V-1:0] done);
      flit_in_wr = wr; hdr_flg_in = hdr; tail_flg_in = 0; vc_num_in = vc;
      dest_e_addr_in = a; destport_in = p; pkt_done = done;
   endtask

   // Clock the inputs in, advance the model, and stop at the falling edge for sampling.
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      drive(0, 0, '0, '0, '0, '0);
   endtask

   task automatic test_reset();
      #2;
      vecs++; if (route_valid !== '0) begin errs++; $display("FAIL reset_valid got %h want 0", route_valid); end
      vecs++; if (dest_e_addr_all !== '0 || destport_all !== '0) begin errs++; $display("FAIL reset_regs got %h/%h want 0", dest_e_addr_all, destport_all); end
      vecs++; if (err_sticky !== '0 || trigger !== 1'b0 || trace !== 32'd0) begin errs++; $display("FAIL reset_dfd got %h/%b/%h want 0", err_sticky, trigger, trace); end
      @(negedge clk); reset = 0; model_clear();
   endtask

   task automatic test_capture();
      drive(1, 1, 4'b0010, 3'd5, 4'd3, '0); step();
      vecs++; if (route_valid !== 4'b0010) begin errs++; $display("FAIL cap_valid got %b want 0010", route_valid); end
      vecs++; if (dest_e_addr_all[5:3] !== 3'd5) begin errs++; $display("FAIL cap_addr got %0d want 5", dest_e_addr_all[5:3]); end
      vecs++; if (destport_all[7:4] !== 4'd3) begin errs++; $display("FAIL cap_port got %0d want 3", destport_all[7:4]); end
      // Body flit on the same VC must not touch the registers.
      drive(1, 0, 4'b0010, 3'd7, 4'd9, '0); step();
      vecs++; if (dest_e_addr_all[5:3] !== 3'd5 || destport_all[7:4] !== 4'd3) begin errs++; $display("FAIL body_hold got %0d/%0d want 5/3", dest_e_addr_all[5:3], destport_all[7:4]); end
   endtask

   task automatic test_release();
      drive(0, 0, '0, '0, '0, 4'b0010); step();
      vecs++; if (route_valid[1] !== 1'b0) begin errs++; $display("FAIL rel_valid got %b want 0", route_valid[1]); end
      vecs++; if (dest_e_addr_all[5:3] !== 3'd5 || destport_all[7:4] !== 4'd3) begin errs++; $display("FAIL rel_hold got %0d/%0d want 5/3", dest_e_addr_all[5:3], destport_all[7:4]); end
      // Release on an idle VC is silently ignored.
      drive(0, 0, '0, '0, '0, 4'b1000); step();
      vecs++; if (err_sticky !== 4'b0000) begin errs++; $display("FAIL idle_done got %b want 0000", err_sticky); end
   endtask

   task automatic test_overwrite_err();
      drive(1, 1, 4'b0010, 3'd5, 4'd3, '0); step();
      drive(1, 1, 4'b0010, 3'd2, 4'd1, '0); step();
      vecs++; if (err_sticky[1] !== 1'b1) begin errs++; $display("FAIL ow_err got %b want 1", err_sticky[1]); end
      vecs++; if (dest_e_addr_all[5:3] !== 3'd5) begin errs++; $display("FAIL ow_addr got %0d want 5", dest_e_addr_all[5:3]); end
`ifdef HEADER_ROUTE_LATCH_DFD_EN
      vecs++; if (trigger !== 1'b1 || trace[15:8] !== 8'd1) begin errs++; $display("FAIL ow_trig got %b/%0d want 1/1", trigger, trace[15:8]); end
`else
      vecs++; if (trigger !== 1'b0 || trace !== 32'd0) begin errs++; $display("FAIL ow_trig got %b/%h want 0/0", trigger, trace); end
`endif
      step();
      vecs++; if (trigger !== 1'b0) begin errs++; $display("FAIL ow_pulse got %b want 0", trigger); end
   endtask

   task automatic test_done_and_capture();
      drive(1, 1, 4'b0100, 3'd1, 4'd2, '0); step();
      drive(1, 1, 4'b0100, 3'd6, 4'd8, 4'b0100); step();
      vecs++; if (route_valid[2] !== 1'b1 || dest_e_addr_all[8:6] !== 3'd6) begin errs++; $display("FAIL dc_cap got %b/%0d want 1/6", route_valid[2], dest_e_addr_all[8:6]); end
      vecs++; if (err_sticky[2] !== 1'b0 || trigger !== 1'b0) begin errs++; $display("FAIL dc_err got %b/%b want 0/0", err_sticky[2], trigger); end
   endtask

   task automatic test_illegal_and_reset();
      logic [V-1:0] v0 = route_valid;
      logic [V*EAw-1:0] a0 = dest_e_addr_all;
      drive(1, 1, 4'b0011, 3'd4, 4'd4, '0); step();
      vecs++; if (route_valid !== v0 || dest_e_addr_all !== a0) begin errs++; $display("FAIL ill_state got %b/%h want %b/%h", route_valid, dest_e_addr_all, v0, a0); end
      vecs++; if (trace !== exp_trace() || trigger !== exp_trig()) begin errs++; $display("FAIL ill_trace got %h/%b want %h/%b", trace, trigger, exp_trace(), exp_trig()); end
      drive(1, 1, 4'b0000, 3'd4, 4'd4, '0); step();
      vecs++; if (trace !== exp_trace()) begin errs++; $display("FAIL zero_vc got %h want %h", trace, exp_trace()); end
      drive(1, 1, 4'b1000, 3'd7, 4'd15, '0); step();
      #2 reset = 1; #1;
      vecs++; if (route_valid !== '0 || dest_e_addr_all !== '0 || destport_all !== '0) begin errs++; $display("FAIL async_rst got %b/%h/%h want 0", route_valid, dest_e_addr_all, destport_all); end
      vecs++; if (err_sticky !== '0 || trigger !== 1'b0 || trace !== 32'd0) begin errs++; $display("FAIL async_rst_dfd got %b/%b/%h want 0", err_sticky, trigger, trace); end
      @(negedge clk); reset = 0; model_clear();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int r = $urandom_range(9);
         logic [V-1:0] vc = (r == 0) ? 4'b0000 : (r == 1) ? 4'($urandom) : 4'(1 << $urandom_range(V-1));
         drive($urandom_range(3) != 0, $urandom_range(1), vc, 3'($urandom), 4'($urandom),
               4'($urandom) & 4'($urandom));
         tail_flg_in = $urandom_range(1);
         step();
         vecs++; if (route_valid !== m_valid) begin errs++; $display("FAIL rnd_valid n=%0d got %b want %b", n, route_valid, m_valid); end
         vecs++; if (dest_e_addr_all !== exp_addr_all()) begin errs++; $display("FAIL rnd_addr n=%0d got %h want %h", n, dest_e_addr_all, exp_addr_all()); end
         vecs++; if (destport_all !== exp_port_all()) begin errs++; $display("FAIL rnd_port n=%0d got %h want %h", n, destport_all, exp_port_all()); end
         vecs++; if (err_sticky !== m_err) begin errs++; $display("FAIL rnd_err n=%0d got %b want %b", n, err_sticky, m_err); end
         vecs++; if (trigger !== exp_trig() || trace !== exp_trace()) begin errs++; $display("FAIL rnd_dfd n=%0d got %b/%h want %b/%h", n, trigger, trace, exp_trig(), exp_trace()); end
      end
   endtask

   task automatic test_saturation();
`ifdef HEADER_ROUTE_LATCH_DFD_EN
      int total = 70000;
`else
      int total = 5000;
`endif
      for (int n = 0; n < total; n++) begin
         drive(1, 1, 4'b0001, 3'($urandom), 4'($urandom), 4'b0001);
         @(posedge clk); model_update();
         if (n % 1000 == 0) begin
            @(negedge clk);
            vecs++; if (trace !== exp_trace() || trigger !== exp_trig()) begin errs++; $display("FAIL sat_run n=%0d got %h/%b want %h/%b", n, trace, trigger, exp_trace(), exp_trig()); end
         end
      end
      @(negedge clk); drive(0, 0, '0, '0, '0, '0);
`ifdef HEADER_ROUTE_LATCH_DFD_EN
      vecs++; if (trace[31:16] !== 16'hFFFF) begin errs++; $display("FAIL sat_hdr got %h want ffff", trace[31:16]); end
`else
      vecs++; if (trace !== 32'd0 || trigger !== 1'b0) begin errs++; $display("FAIL sat_off got %h/%b want 0/0", trace, trigger); end
`endif
      vecs++; if (route_valid !== m_valid || dest_e_addr_all !== exp_addr_all()) begin errs++; $display("FAIL sat_state got %b/%h want %b/%h", route_valid, dest_e_addr_all, m_valid, exp_addr_all()); end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_capture();
      test_release();
      test_overwrite_err();
      test_done_and_capture();
      test_illegal_and_reset();
      test_random();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
